ccx_emu: RTL and testbench

Parametrised, chunk-serial emulator for a FazyRV custom-instruction (CCX) unit, used in FPGA emulation wrappers. It accepts one operation request plus a stream of operand chunks from the core, computes a selectable ALU function chunk by chunk, and returns result chunks through a configurable delay line. A one-cycle response pulse marks the last result chunk. It generalises the fixed AND-only, fixed-delay CCX shim: chunk width, word width and latency are configurable, four operations are supported (including carry-chained ADD), and the block tracks busy state and flags protocol errors.

---
 rtl/ccx_emu_pkg.sv | 30 +++
 rtl/ccx_emu_dly.sv | 31 +++
 rtl/ccx_emu.sv | 137 +++++++++++++
 tb/tb_ccx_emu.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccx_emu_pkg.sv
// Shared types for the chunk-serial CCX emulator: opcodes, FSM states and
// the delay-line stage record.
package ccx_emu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } ccx_op_e;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } ccx_state_e;

  // Widest chunk the emulator supports; narrower builds use the low data bits.
  localparam int unsigned CHUNK_MAX = 8;

  typedef struct packed {
    logic [CHUNK_MAX-1:0] data;
    logic                 valid;
    logic                 last;
  } ccx_stage_t;

  function automatic bit ccx_legal_chunk(input int unsigned cs);
    return (cs == 1) || (cs == 2) || (cs == 4) || (cs == 8);
  endfunction

endpackage

// File: rtl/ccx_emu_dly.sv
// Generic W-bit, D-deep shift delay line; every stage clears on reset.
module ccx_emu_dly
  import ccx_emu_pkg::*;
#(
  parameter int unsigned W = 6,
  parameter int unsigned D = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (D < 1) begin : g_chk_depth
    $error("ccx_emu_dly: D must be at least 1");
  end

  logic [W-1:0] stage_p [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < D; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[D-1];

endmodule

// File: rtl/ccx_emu.sv
// Chunk-serial CCX emulator: collects operand chunks, applies AND/OR/XOR/ADD
// per chunk and returns results through a fixed-latency delay line.
module ccx_emu
  import ccx_emu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CHUNKSIZE = 4,
  parameter int unsigned RES_DLY   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic [1:0]           sel_i,
  input  logic [CHUNKSIZE-1:0] rs_a_i,
  input  logic [CHUNKSIZE-1:0] rs_b_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 res_valid_o,
  output logic                 resp_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned N     = XLEN / CHUNKSIZE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  if (XLEN % CHUNKSIZE != 0) begin : g_chk_div
    $error("ccx_emu: XLEN must be a multiple of CHUNKSIZE");
  end
  if (RES_DLY < 1) begin : g_chk_dly
    $error("ccx_emu: RES_DLY must be at least 1");
  end
  if (!ccx_legal_chunk(CHUNKSIZE)) begin : g_chk_chunk
    $error("ccx_emu: CHUNKSIZE must be 1, 2, 4 or 8");
  end

  typedef struct packed {
    logic [CHUNKSIZE-1:0] data;
    logic                 valid;
    logic                 last;
  } stage_t;

  ccx_state_e           state;
  logic [CNT_W-1:0]     cnt;
  ccx_op_e              op_q;
  logic                 carry_q;
  logic                 err_q;

  logic                 in_collect;
  logic                 proc;
  ccx_op_e              cur_op;
  logic                 cin;
  logic [CNT_W-1:0]     idx;
  logic                 is_last;
  logic [CHUNKSIZE:0]   sum;
  logic [CHUNKSIZE-1:0] res_chunk;
  stage_t               head;
  stage_t               tail;

  // Chunk 0 takes its opcode straight from sel_i and starts with carry 0;
  // later chunks use the latched opcode and the running carry.
  assign in_collect = (state == COLLECT);
  assign proc       = in_collect | req_i;
  assign cur_op     = in_collect ? op_q : ccx_op_e'(sel_i);
  assign cin        = in_collect & carry_q;
  assign idx        = in_collect ? cnt : '0;
  assign is_last    = (idx == LAST_IDX);
  assign sum        = {1'b0, rs_a_i} + {1'b0, rs_b_i} + {{CHUNKSIZE{1'b0}}, cin};

  always_comb begin
    res_chunk = '0;
    unique case (cur_op)
      OP_AND:  res_chunk = rs_a_i & rs_b_i;
      OP_OR:   res_chunk = rs_a_i | rs_b_i;
      OP_XOR:  res_chunk = rs_a_i ^ rs_b_i;
      OP_ADD:  res_chunk = sum[CHUNKSIZE-1:0];
      default: res_chunk = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_AND;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= in_collect & req_i;
      if (proc) carry_q <= (cur_op == OP_ADD) & sum[CHUNKSIZE];
      unique case (state)
        IDLE: begin
          if (req_i) begin
            op_q <= cur_op;
            // A single-chunk word completes in the request cycle itself.
            if (N > 1) begin
              state <= COLLECT;
              cnt   <= CNT_W'(1);
            end
          end
        end
        COLLECT: begin
          if (is_last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stage boundary: result record enters the RES_DLY-deep delay line.
  assign head = '{data: res_chunk, valid: proc, last: proc & is_last};

  ccx_emu_dly #(
    .W (CHUNKSIZE + 2),
    .D (RES_DLY)
  ) u_dly (
    .clk   (clk_i),
    .rst_n (rst_n),
    .din   (head),
    .dout  (tail)
  );

  assign res_valid_o = tail.valid;
  assign res_o       = tail.data & {CHUNKSIZE{tail.valid}};
  assign resp_o      = tail.valid & tail.last;
  assign busy_o      = in_collect;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ccx_emu.sv
// Scoreboard bench for ccx_emu: default build plus CHUNKSIZE=1/8, RES_DLY=1 builds.
module tb_ccx_emu;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default build: XLEN=32, CHUNKSIZE=4, RES_DLY=5
  logic       req = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] a = 4'd0, b = 4'd0, res;
  logic       res_valid, resp, busy, err;

  // sweep builds
  logic       req1 = 1'b0, req8 = 1'b0;
  logic [1:0] sel1 = 2'd0, sel8 = 2'd0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0, res1;
  logic [7:0] a8 = 8'd0, b8 = 8'd0, res8;
  logic       vld1, resp1, busy1, err1, vld8, resp8, busy8, err8;

  ccx_emu #(.XLEN(32), .CHUNKSIZE(4), .RES_DLY(5)) u_dut (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .sel_i(sel), .rs_a_i(a), .rs_b_i(b),
    .res_o(res), .res_valid_o(res_valid), .resp_o(resp), .busy_o(busy), .err_o(err));

  ccx_emu #(.XLEN(32), .CHUNKSIZE(1), .RES_DLY(1)) u_s1 (
    .clk_i(clk), .rst_n(rst_n), .req_i(req1), .sel_i(sel1), .rs_a_i(a1), .rs_b_i(b1),
    .res_o(res1), .res_valid_o(vld1), .resp_o(resp1), .busy_o(busy1), .err_o(err1));

  ccx_emu #(.XLEN(32), .CHUNKSIZE(8), .RES_DLY(1)) u_s8 (
    .clk_i(clk), .rst_n(rst_n), .req_i(req8), .sel_i(sel8), .rs_a_i(a8), .rs_b_i(b8),
    .res_o(res8), .res_valid_o(vld8), .resp_o(resp8), .busy_o(busy8), .err_o(err8));

  int checks = 0, failures = 0;

  exp_t q_m[$], q1[$], q8[$];
  exp_t em, e1, e8;

  int          valid_cnt = 0, first_vld = -1, last_vld = -1, resp_cnt = 0, busy_cnt = 0;
  int          obs_idx = 0;
  int          resp_cyc[$], err_cyc[$];
  logic [31:0] obs_word = '0;
  logic [31:0] word_q[$];

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return x + y;
    endcase
  endfunction

  // Main scoreboard: pops one expected chunk per valid output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (err) err_cyc.push_back(cyc);
      checks++;
      if (res_valid) begin
        valid_cnt++;
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
        obs_word[(obs_idx % 8) * 4 +: 4] = res;
        obs_idx = resp ? 0 : obs_idx + 1;
        if (resp) begin
          resp_cnt++;
          resp_cyc.push_back(cyc);
          word_q.push_back(obs_word);
        end
        if (q_m.size() == 0) begin
          failures++;
          $display("FAIL main_unexpected cyc=%0d res=%h resp=%b", cyc, res, resp);
        end else begin
          em = q_m.pop_front();
          if (res !== em.data[3:0] || resp !== em.last || cyc != em.cyc) begin
            failures++;
            $display("FAIL main_chunk got cyc=%0d res=%h resp=%b expected cyc=%0d res=%h resp=%b",
                     cyc, res, resp, em.cyc, em.data[3:0], em.last);
          end
        end
      end else if (res !== 4'd0 || resp !== 1'b0) begin
        failures++;
        $display("FAIL main_idle cyc=%0d res=%h resp=%b expected 0/0", cyc, res, resp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL s1_unexpected cyc=%0d res=%b", cyc, res1);
      end else begin
        e1 = q1.pop_front();
        if (res1 !== e1.data[0:0] || resp1 !== e1.last || cyc != e1.cyc) begin
          failures++;
          $display("FAIL s1_chunk got cyc=%0d res=%b resp=%b expected cyc=%0d res=%b resp=%b",
                   cyc, res1, resp1, e1.cyc, e1.data[0], e1.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL s8_unexpected cyc=%0d res=%h", cyc, res8);
      end else begin
        e8 = q8.pop_front();
        if (res8 !== e8.data || resp8 !== e8.last || cyc != e8.cyc) begin
          failures++;
          $display("FAIL s8_chunk got cyc=%0d res=%h resp=%b expected cyc=%0d res=%h resp=%b",
                   cyc, res8, resp8, e8.cyc, e8.data, e8.last);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8-chunk operation; glitch_k >= 0 raises an extra req on that chunk.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] wa, input logic [31:0] wb, input int glitch_k);
    logic [31:0] w;
    int t0;
    w  = golden(op, wa, wb);
    t0 = cyc;
    for (int k = 0; k < 8; k++)
      q_m.push_back('{cyc: t0 + 5 + k, data: {4'd0, w[k*4 +: 4]}, last: (k == 7)});
    for (int k = 0; k < 8; k++) begin
      req = (k == 0) || (k == glitch_k);
      sel = (k == 0) ? op : ~op;
      a   = wa[k*4 +: 4];
      b   = wb[k*4 +: 4];
      @(posedge clk);
      #1;
    end
    req = 1'b0; a = 4'd0; b = 4'd0;
  endtask

  task automatic clear_stats();
    valid_cnt = 0; first_vld = -1; last_vld = -1; busy_cnt = 0;
    resp_cyc.delete(); err_cyc.delete(); word_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    checks++;
    if ({res, res_valid, resp, busy, err} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 0", {res, res_valid, resp, busy, err});
    end
    rst_n = 1'b1;
    wait_cycles(2);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b valid=%b expected 0/0", busy, res_valid);
    end
  endtask

  task automatic test_and();
    int t0;
    clear_stats();
    t0 = cyc;
    drive_op(2'd0, 32'hF0F0_1234, 32'hFF00_FF0F, -1);
    wait_cycles(6);
    checks++;
    if (resp_cyc.size() != 1 || resp_cyc[0] != t0 + 12) begin
      failures++;
      $display("FAIL and_resp_time got n=%0d first=%0d expected one at %0d",
               resp_cyc.size(), (resp_cyc.size() > 0) ? resp_cyc[0] : -1, t0 + 12);
    end
    checks++;
    if (word_q.size() != 1 || word_q[0] !== 32'hF000_1204) begin
      failures++;
      $display("FAIL and_word got %h expected f0001204", (word_q.size() > 0) ? word_q[0] : 32'hx);
    end
  endtask

  task automatic test_add();
    clear_stats();
    drive_op(2'd3, 32'h0000_000F, 32'h0000_0001, -1);
    drive_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    drive_op(2'd3, 32'h7FFF_FFFF, 32'h0000_0001, -1);
    wait_cycles(6);
    checks++;
    if (word_q.size() != 3 || word_q[0] !== 32'h0000_0010 || word_q[1] !== 32'h0 || word_q[2] !== 32'h8000_0000) begin
      failures++;
      $display("FAIL add_words got n=%0d expected 00000010,00000000,80000000", word_q.size());
    end
    checks++;
    if (err_cyc.size() != 0) begin
      failures++;
      $display("FAIL add_err got %0d pulses expected 0", err_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_stats();
    t0 = cyc;
    drive_op(2'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, -1);
    drive_op(2'd1, 32'h0000_0000, 32'h8000_0001, -1);
    wait_cycles(7);
    checks++;
    if (first_vld != t0 + 5 || last_vld != t0 + 20 || valid_cnt != 16) begin
      failures++;
      $display("FAIL b2b_valid_window got first=%0d last=%0d n=%0d expected %0d %0d 16",
               first_vld, last_vld, valid_cnt, t0 + 5, t0 + 20);
    end
    checks++;
    if (resp_cyc.size() != 2 || resp_cyc[0] != t0 + 12 || resp_cyc[1] != t0 + 20) begin
      failures++;
      $display("FAIL b2b_resp got n=%0d expected at %0d and %0d", resp_cyc.size(), t0 + 12, t0 + 20);
    end
    checks++;
    if (word_q.size() != 2 || word_q[0] !== 32'hF0F0_0F0F || word_q[1] !== 32'h8000_0001) begin
      failures++;
      $display("FAIL b2b_words got n=%0d expected f0f00f0f,80000001", word_q.size());
    end
  endtask

  task automatic test_protocol_error();
    int t0;
    clear_stats();
    t0 = cyc;
    drive_op(2'd3, 32'h1234_5678, 32'h1111_1111, 3);
    wait_cycles(6);
    checks++;
    if (err_cyc.size() != 1 || err_cyc[0] != t0 + 4) begin
      failures++;
      $display("FAIL proto_err got n=%0d first=%0d expected one at %0d",
               err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, t0 + 4);
    end
    checks++;
    if (word_q.size() != 1 || word_q[0] !== 32'h2345_6789) begin
      failures++;
      $display("FAIL proto_word got n=%0d expected single 23456789", word_q.size());
    end
    checks++;
    if (busy_cnt != 7) begin
      failures++;
      $display("FAIL proto_busy got %0d busy cycles expected 7", busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int t0, base;
    clear_stats();
    t0 = cyc;
    q_m.push_back('{cyc: t0 + 5, data: 8'h0F, last: 1'b0});
    for (int k = 0; k < 6; k++) begin
      req = (k == 0); sel = 2'd0; a = 4'hF; b = 4'hF;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    req = 1'b0; a = 4'd0; b = 4'd0;
    #1;
    checks++;
    if ({res, res_valid, resp, busy, err} !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got %b expected 0", {res, res_valid, resp, busy, err});
    end
    base = resp_cnt;
    wait_cycles(2);
    rst_n   = 1'b1;
    obs_idx = 0;
    drive_op(2'd3, 32'd1, 32'd1, -1);
    wait_cycles(6);
    checks++;
    if (resp_cnt != base + 1 || word_q.size() != 1 || word_q[0] !== 32'd2) begin
      failures++;
      $display("FAIL rstmid_after got resps=%0d expected %0d with word 00000002", resp_cnt, base + 1);
    end
  endtask

  task automatic test_sweep(input int iters);
    logic [1:0]  op;
    logic [31:0] wa, wb, w;
    int t0;
    for (int it = 0; it < iters; it++) begin
      op = 2'($urandom_range(0, 3)); wa = $urandom; wb = $urandom;
      w  = golden(op, wa, wb);
      t0 = cyc;
      for (int k = 0; k < 32; k++)
        q1.push_back('{cyc: t0 + 1 + k, data: {7'd0, w[k]}, last: (k == 31)});
      for (int k = 0; k < 32; k++) begin
        req1 = (k == 0); sel1 = (k == 0) ? op : ~op; a1 = wa[k]; b1 = wb[k];
        @(posedge clk);
        #1;
      end
      req1 = 1'b0;
      if ($urandom_range(0, 3) == 0) wait_cycles(1);
    end
    for (int it = 0; it < iters; it++) begin
      op = 2'($urandom_range(0, 3)); wa = $urandom; wb = $urandom;
      w  = golden(op, wa, wb);
      t0 = cyc;
      for (int k = 0; k < 4; k++)
        q8.push_back('{cyc: t0 + 1 + k, data: w[k*8 +: 8], last: (k == 3)});
      for (int k = 0; k < 4; k++) begin
        req8 = (k == 0); sel8 = (k == 0) ? op : ~op; a8 = wa[k*8 +: 8]; b8 = wb[k*8 +: 8];
        @(posedge clk);
        #1;
      end
      req8 = 1'b0;
      if ($urandom_range(0, 3) == 0) wait_cycles(1);
    end
    wait_cycles(4);
    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL sweep_drain got pending s1=%0d s8=%0d expected 0/0", q1.size(), q8.size());
    end
    checks++;
    if ({busy1, err1, busy8, err8} !== 4'd0) begin
      failures++;
      $display("FAIL sweep_idle got %b expected 0000", {busy1, err1, busy8, err8});
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_add();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid();
    test_sweep(1000);
    checks++;
    if (q_m.size() != 0) begin
      failures++;
      $display("FAIL main_drain got %0d pending expected 0", q_m.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
